// File: rtl/noc_cfg_pkg.sv
// noc_cfg_pkg
// Shared types for the NoC router configuration master: port encoding,
// request command encoding, FSM state type, shadow-table entry and the
// packed request word stored in the request FIFO.
package noc_cfg_pkg;

  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    PORT_A = 2'd0,
    PORT_B = 2'd1,
    PORT_C = 2'd2,
    PORT_D = 2'd3
  } port_e;

  localparam logic CMD_CONNECT    = 1'b0;
  localparam logic CMD_DISCONNECT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_CFG,
    S_LD,
    S_SETTLE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] in_port;
  } tbl_entry_t;

  typedef struct packed {
    logic  cmd;
    port_e src;
    port_e dst;
  } req_t;

endpackage

// File: rtl/noc_cfg_fifo.sv
// noc_cfg_fifo
// Synchronous request FIFO with registered not_full/empty flags.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wdata     write strobe (ignored when full) and data
//   pop, rdata      read strobe (ignored when empty); rdata shows the head
//   not_full, empty registered occupancy flags
module noc_cfg_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         not_full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && not_full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      not_full <= 1'b1;
      empty    <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      not_full <= (count_nxt != (AW+1)'(DEPTH));
      empty    <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/noc_cfg_master.sv
// noc_cfg_master
// Configuration initiator for the 4-port NoC router. Route requests are
// queued in a FIFO; connects become a CS/CNFG then CS/LOAD bus sequence
// followed by an optional settle wait, disconnects and clears update the
// shadow connection table and the per-output tristate enables en_o.
// Optional feature macro: NOC_CFG_CONFLICT_CHECK_EN (reject conflicting
// connects and disconnects of unrouted outputs with an err_o pulse).
// Ports:
//   CLK, RES_in                     clock, asynchronous active-high reset
//   req_valid_i/req_ready_o         request handshake
//   req_cmd_i, req_in_i, req_out_i  request command and port pair
//   clr_i                           router reset request pulse
//   CS, CNFG, LOAD, RES             router strobes
//   In_add, out_add                 router addresses
//   en_o                            router tristate enables
//   done_o, err_o, busy_o           completion/reject pulses, FSM busy
module noc_cfg_master
  import noc_cfg_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RES_in,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_cmd_i,
  input  logic [1:0] req_in_i,
  input  logic [1:0] req_out_i,
  input  logic       clr_i,
  output logic       CS,
  output logic       CNFG,
  output logic       LOAD,
  output logic       RES,
  output logic [1:0] In_add,
  output logic [1:0] out_add,
  output logic [3:0] en_o,
  output logic       done_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_e           state;
  tbl_entry_t       tbl [NUM_PORTS];
  logic [CNT_W-1:0] settle_cnt;
  logic             clr_pend;
  logic             resp_done;
  req_t             wr_req;
  req_t             head;
  logic             fifo_empty;
  logic             clr_go;
  logic             pop;

  assign wr_req = '{cmd: req_cmd_i, src: port_e'(req_in_i), dst: port_e'(req_out_i)};
  assign clr_go = clr_pend || clr_i;
  assign pop    = (state == S_IDLE) && !clr_go && !fifo_empty;

  noc_cfg_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(req_t))
  ) u_fifo (
    .clk      (CLK),
    .rst      (RES_in),
    .push     (req_valid_i),
    .wdata    (wr_req),
    .pop      (pop),
    .rdata    (head),
    .not_full (req_ready_o),
    .empty    (fifo_empty)
  );

`ifdef NOC_CFG_CONFLICT_CHECK_EN
  logic conflict;
  logic resp_err;

  // Reject if the output is owned by another input, or the input already
  // drives a different output.
  always_comb begin
    conflict = tbl[head.dst].valid && (tbl[head.dst].in_port != head.src);
    for (int o = 0; o < NUM_PORTS; o++) begin
      if ((o[1:0] != head.dst) && tbl[o].valid && (tbl[o].in_port == head.src))
        conflict = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RES_in) begin
    if (RES_in)
      err_o <= 1'b0;
    else
      err_o <= resp_err;
  end
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RES_in) begin
    if (RES_in) begin
      state      <= S_IDLE;
      CS         <= 1'b0;
      CNFG       <= 1'b0;
      LOAD       <= 1'b0;
      RES        <= 1'b0;
      In_add     <= '0;
      out_add    <= '0;
      en_o       <= '0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
      clr_pend   <= 1'b0;
      resp_done  <= 1'b0;
      settle_cnt <= '0;
      for (int i = 0; i < NUM_PORTS; i++)
        tbl[i] <= '0;
`ifdef NOC_CFG_CONFLICT_CHECK_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      CS        <= 1'b0;
      CNFG      <= 1'b0;
      LOAD      <= 1'b0;
      RES       <= 1'b0;
      // IDLE-side completions are reported one cycle after the pop.
      done_o    <= resp_done;
      resp_done <= 1'b0;
`ifdef NOC_CFG_CONFLICT_CHECK_EN
      resp_err  <= 1'b0;
`endif
      // A clear arriving mid-sequence waits; one arriving during RST is absorbed.
      if (clr_i && (state != S_IDLE) && (state != S_RST))
        clr_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (clr_go) begin
            state    <= S_RST;
            CS       <= 1'b1;
            RES      <= 1'b1;
            busy_o   <= 1'b1;
            clr_pend <= 1'b0;
            en_o     <= '0;
            for (int i = 0; i < NUM_PORTS; i++)
              tbl[i] <= '0;
          end else if (!fifo_empty) begin
            if (head.cmd == CMD_DISCONNECT) begin
`ifdef NOC_CFG_CONFLICT_CHECK_EN
              if (!tbl[head.dst].valid) begin
                resp_err <= 1'b1;
              end else begin
                tbl[head.dst]  <= '0;
                en_o[head.dst] <= 1'b0;
                resp_done      <= 1'b1;
              end
`else
              tbl[head.dst]  <= '0;
              en_o[head.dst] <= 1'b0;
              resp_done      <= 1'b1;
`endif
            end
`ifdef NOC_CFG_CONFLICT_CHECK_EN
            else if (conflict) begin
              resp_err <= 1'b1;
            end
`endif
            else begin
              state   <= S_CFG;
              CS      <= 1'b1;
              CNFG    <= 1'b1;
              In_add  <= head.src;
              out_add <= head.dst;
              busy_o  <= 1'b1;
            end
          end
        end

        S_RST: begin
          state  <= S_IDLE;
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end

        S_CFG: begin
          state <= S_LD;
          CS    <= 1'b1;
          LOAD  <= 1'b1;
        end

        // LD and SETTLE share the exit into DONE; the table and enable are
        // updated on that edge so en_o is visible together with done_o.
        S_LD, S_SETTLE: begin
          if ((state == S_LD) && (SETTLE_CYCLES != 0)) begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_INIT;
          end else if ((state == S_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else begin
            state         <= S_DONE;
            done_o        <= 1'b1;
            tbl[out_add]  <= '{valid: 1'b1, in_port: In_add};
            en_o[out_add] <= 1'b1;
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_cfg_master.sv
module tb_noc_cfg_master;

  logic       CLK = 1'b0;
  logic       RES_in;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_cmd_i;
  logic [1:0] req_in_i;
  logic [1:0] req_out_i;
  logic       clr_i;
  logic       CS, CNFG, LOAD, RES;
  logic [1:0] In_add, out_add;
  logic [3:0] en_o;
  logic       done_o, err_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         err;
    logic [3:0] en;
    logic [1:0] a_in;
    logic [1:0] a_out;
  } exp_t;

  exp_t sb[$];

  noc_cfg_master #(.DEPTH(4), .SETTLE_CYCLES(2)) dut (
    .CLK         (CLK),
    .RES_in      (RES_in),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_cmd_i   (req_cmd_i),
    .req_in_i    (req_in_i),
    .req_out_i   (req_out_i),
    .clr_i       (clr_i),
    .CS          (CS),
    .CNFG        (CNFG),
    .LOAD        (LOAD),
    .RES         (RES),
    .In_add      (In_add),
    .out_add     (out_add),
    .en_o        (en_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_resp(input bit err, input logic [3:0] en,
                             input logic [1:0] a_in, input logic [1:0] a_out);
    exp_t e;
    e.err = err; e.en = en; e.a_in = a_in; e.a_out = a_out;
    sb.push_back(e);
  endtask

  // Holds the request until an edge sees ready; returns with time just
  // after the accepting edge. stalls counts edges skipped for !ready.
  task automatic push(input logic cmd, input logic [1:0] src, input logic [1:0] dst,
                      output int stalls);
    stalls      = 0;
    req_valid_i = 1'b1;
    req_cmd_i   = cmd;
    req_in_i    = src;
    req_out_i   = dst;
    while (!req_ready_o && stalls < 50) begin
      step();
      stalls++;
    end
    if (!req_ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: ready got 0 expected 1");
    end
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy_o) && k < max_cycles) begin
      step();
      k++;
    end
    if (sb.size() != 0 || busy_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: pending got %0d expected 0", sb.size());
    end
  endtask

  // Scoreboard monitor: every done/err pulse must match the next expectation.
  always @(posedge CLK) begin
    exp_t e;
    #2;
    if (done_o || err_o) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: done=%0b err=%0b expected no response", done_o, err_o);
      end else begin
        e = sb.pop_front();
        chk("sb_kind", {30'd0, done_o, err_o}, e.err ? 32'd1 : 32'd2);
        chk("sb_en", {28'd0, en_o}, {28'd0, e.en});
        chk("sb_addr", {28'd0, In_add, out_add}, {28'd0, e.a_in, e.a_out});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time got %0t expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic cnfg_seen;

    RES_in      = 1'b1;
    req_valid_i = 1'b0;
    req_cmd_i   = 1'b0;
    req_in_i    = 2'd0;
    req_out_i   = 2'd0;
    clr_i       = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_strobes", {28'd0, CS, CNFG, LOAD, RES}, 32'd0);
    chk("rst_en", {28'd0, en_o}, 32'd0);
    chk("rst_flags", {29'd0, done_o, err_o, busy_o}, 32'd0);
    @(negedge CLK);
    RES_in = 1'b0;
    step();

    // Connect A->C: bus sequence timing
    expect_resp(0, 4'b0100, 2'd0, 2'd2);
    push(1'b0, 2'd0, 2'd2, st);
    step();
    chk("cfg_strobes", {28'd0, CS, CNFG, LOAD, RES}, 32'b1100);
    chk("cfg_addr", {28'd0, In_add, out_add}, 32'b0010);
    chk("cfg_busy", {31'd0, busy_o}, 32'd1);
    step();
    chk("ld_strobes", {28'd0, CS, CNFG, LOAD, RES}, 32'b1010);
    step();
    chk("settle_strobes", {28'd0, CS, CNFG, LOAD, RES}, 32'b0000);
    chk("settle_addr", {28'd0, In_add, out_add}, 32'b0010);
    step();
    chk("done_t4", {31'd0, done_o}, 32'd0);
    step();
    chk("done_t5", {31'd0, done_o}, 32'd1);
    step();
    chk("after_done_busy", {31'd0, busy_o}, 32'd0);

    // Disconnect out=2
    expect_resp(0, 4'b0000, 2'd0, 2'd2);
    push(1'b1, 2'd0, 2'd2, st);
    step();
    chk("disc2_t1_done", {31'd0, done_o}, 32'd0);
    chk("disc2_t1_en", {28'd0, en_o}, 32'd0);
    step();
    chk("disc2_t2_done", {31'd0, done_o}, 32'd1);
    step();

    // FIFO back-pressure: first connect keeps the FSM busy, then 5 more
    expect_resp(0, 4'b0001, 2'd0, 2'd0);
    push(1'b0, 2'd0, 2'd0, st);
    step();
    expect_resp(0, 4'b0011, 2'd1, 2'd1);
    push(1'b0, 2'd1, 2'd1, st);
    expect_resp(0, 4'b0111, 2'd2, 2'd2);
    push(1'b0, 2'd2, 2'd2, st);
    expect_resp(0, 4'b1111, 2'd3, 2'd3);
    push(1'b0, 2'd3, 2'd3, st);
    expect_resp(0, 4'b1111, 2'd0, 2'd0);
    push(1'b0, 2'd0, 2'd0, st);
    chk("fifo_full_ready", {31'd0, req_ready_o}, 32'd0);
    expect_resp(0, 4'b1111, 2'd1, 2'd1);
    push(1'b0, 2'd1, 2'd1, st);
    chk("fifo_fifth_stalls", st, 32'd2);
    wait_idle(200);

    // Clear during SETTLE
    expect_resp(0, 4'b0111, 2'd1, 2'd1);
    push(1'b1, 2'd0, 2'd3, st);
    wait_idle(20);
    expect_resp(0, 4'b1111, 2'd3, 2'd3);
    expect_resp(0, 4'b0000, 2'd3, 2'd3);
    push(1'b0, 2'd3, 2'd3, st);
    step();
    step();
    step();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    step();
    chk("clr_seq_done", {31'd0, done_o}, 32'd1);
    chk("clr_seq_en", {28'd0, en_o}, 32'b1111);
    step();
    chk("clr_idle_res", {31'd0, RES}, 32'd0);
    step();
    chk("clr_rst_strobes", {28'd0, CS, CNFG, LOAD, RES}, 32'b1001);
    chk("clr_rst_en", {28'd0, en_o}, 32'd0);
    step();
    chk("clr_done", {31'd0, done_o}, 32'd1);
    chk("clr_res_low", {31'd0, RES}, 32'd0);
    step();

    // Connect A->B
    expect_resp(0, 4'b0010, 2'd0, 2'd1);
    push(1'b0, 2'd0, 2'd1, st);
    wait_idle(20);

`ifdef NOC_CFG_CONFLICT_CHECK_EN
    // Conflicting connect C->B is rejected without a bus cycle
    expect_resp(1, 4'b0010, 2'd0, 2'd1);
    push(1'b0, 2'd2, 2'd1, st);
    cnfg_seen = 1'b0;
    step();
    cnfg_seen |= CNFG;
    chk("conf_err_t1", {31'd0, err_o}, 32'd0);
    step();
    cnfg_seen |= CNFG;
    chk("conf_err_t2", {31'd0, err_o}, 32'd1);
    step();
    cnfg_seen |= CNFG;
    chk("conf_no_cnfg", {31'd0, cnfg_seen}, 32'd0);
    chk("conf_en", {28'd0, en_o}, 32'b0010);
    // Disconnect of an unrouted output
    expect_resp(1, 4'b0010, 2'd0, 2'd1);
    push(1'b1, 2'd0, 2'd3, st);
    wait_idle(20);
`endif

    // Disconnect out=1
    expect_resp(0, 4'b0000, 2'd0, 2'd1);
    push(1'b1, 2'd0, 2'd1, st);
    step();
    chk("disc1_t1_done", {31'd0, done_o}, 32'd0);
    chk("disc1_t1_en", {28'd0, en_o}, 32'd0);
    step();
    chk("disc1_t2_done", {31'd0, done_o}, 32'd1);
    step();

    // Asynchronous reset during LD
    push(1'b0, 2'd0, 2'd3, st);
    step();
    step();
    chk("ld_before_rst", {28'd0, CS, CNFG, LOAD, RES}, 32'b1010);
    #2;
    RES_in = 1'b1;
    #1;
    chk("arst_strobes", {28'd0, CS, CNFG, LOAD, RES}, 32'd0);
    chk("arst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("arst_flags", {29'd0, done_o, err_o, busy_o}, 32'd0);
    chk("arst_addr", {28'd0, In_add, out_add}, 32'd0);
    @(negedge CLK);
    RES_in = 1'b0;
    cnfg_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      cnfg_seen |= busy_o | CS;
    end
    chk("arst_fifo_empty", {31'd0, cnfg_seen}, 32'd0);
    chk("arst_en", {28'd0, en_o}, 32'd0);

    chk("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_cfg_master.md
# noc_cfg_master

Configuration initiator for the 4-port NoC router. It accepts route requests (input port -> output port) over a valid/ready interface and queues them in a small FIFO. Each connect request becomes a router programming sequence on the router's CS/CNFG/LOAD/RES/In_add/out_add pins. The block also keeps a shadow connection table and drives the per-output tristate enables `en_o` for the router.

## Interface
Parameters:
- DEPTH, 4: request FIFO depth; power of two, minimum 2.
- SETTLE_CYCLES, 2: cycles held after LOAD before completion; 0 means no SETTLE state.

Ports:
- CLK  in  1  sole clock; all logic on the rising edge.
- RES_in  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  FIFO not full.
- req_cmd_i  in  1  0 = connect, 1 = disconnect.
- req_in_i  in  2  source input port (0=A .. 3=D).
- req_out_i  in  2  destination output port.
- clr_i  in  1  single-cycle pulse; requests a router reset.
- CS  out  1  router chip select.
- CNFG  out  1  router configure strobe.
- LOAD  out  1  router load strobe.
- RES  out  1  router reset strobe.
- In_add  out  2  router input address.
- out_add  out  2  router output address.
- en_o  out  4  router tristate enables; bit n maps to output n.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle reject pulse.
- busy_o  out  1  FSM not in IDLE.

## Operation
- All outputs are registered. On reset, every output is 0 except req_ready_o, which is 1. The FIFO, connection table and pending-clear flag are all cleared.
- FIFO: a push happens when req_valid_i && req_ready_o. req_ready_o = !full. A push and a pop in the same cycle are legal; the count stays unchanged. Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, RST, CFG, LD, SETTLE, DONE.
- IDLE priority:
  - Pending clear first: go to RST.
  - Otherwise, if the FIFO is non-empty, pop the head entry.
  - Connect: go to CFG.
  - Disconnect: clear table[out] and en_o[out], pulse done_o next cycle, stay in IDLE. No router bus cycle is issued.
- RST (1 cycle): CS=1, RES=1. This clears the whole table and en_o. FIFO contents are kept. Then go to IDLE and pulse done_o.
- CFG (1 cycle): CS=1, CNFG=1, In_add=in, out_add=out.
- LD (1 cycle): CS=1, LOAD=1, addresses held. Then go to SETTLE, or to DONE if SETTLE_CYCLES=0.
- SETTLE: CS=0, addresses held, down-counter from SETTLE_CYCLES-1 to 0. Then go to DONE.
- DONE (1 cycle): done_o=1. Write table[out] = {valid, in} and set en_o[out]=1. Then go to IDLE.
- clr_i received in any non-IDLE state sets the pending flag; the current sequence finishes first. A clr_i during RST is absorbed.
- Outside the states listed above, CS/CNFG/LOAD/RES are 0. In_add and out_add keep their last value.
- RES_in asserted mid-sequence: all strobes drop to 0 immediately (asynchronous).

## Timing
- A connect accepted at edge t0 with an empty FIFO and the FSM in IDLE:
  - CFG occupies cycle t1.
  - LD occupies cycle t2.
  - SETTLE occupies cycles t3 .. t2+SETTLE_CYCLES.
  - done_o is high in cycle t3+SETTLE_CYCLES, which is t5 for the default.
- Back-to-back connects: 4+SETTLE_CYCLES cycles each, including one IDLE cycle per request.
- A disconnect completes with done_o two cycles after acceptance.
- Clear: RES is high for 1 cycle; done_o follows 1 cycle later.

## Configuration
- NOC_CFG_CONFLICT_CHECK_EN defined:
  - A connect is rejected in IDLE, with err_o pulsed next cycle and no bus cycle issued, when:
    - table[out] is valid with a different input, or
    - the requested input is already routed to another output.
  - A disconnect to an output whose table entry is not valid also pulses err_o instead of done_o.
- Undefined: every connect is programmed and overwrites table[out]. err_o is tied to 0.

## Structure
- Shared package `noc_cfg_pkg`:
  - Port enum A=0..D=3.
  - Command encodings.
  - FSM state typedef.
  - Table-entry struct {valid, in[1:0]}.
- One sub-module: `noc_cfg_fifo`, the parameterised sync FIFO with full/empty flags. The FSM, table and strobe drivers stay in the top module.

## Test plan
- Connect A->C (in=0, out=2), SETTLE_CYCLES=2:
  - CS+CNFG with In_add=0, out_add=2 at t1; CS+LOAD at t2.
  - done_o at t5; en_o=4'b0100.
- Push 5 connects with DEPTH=4 while the FSM is busy:
  - req_ready_o drops after the 4th push.
  - The 5th is accepted only after the first pop.
  - All 5 complete in order.
- clr_i pulsed during SETTLE:
  - The sequence finishes first (done_o, en_o bit set).
  - Then RES+CS for 1 cycle, en_o=0, then a done pulse.
- With NOC_CFG_CONFLICT_CHECK_EN, connect A->B, then connect C->B:
  - The second request gets an err_o pulse; no CNFG is seen on the bus.
  - en_o stays 4'b0010.
- Disconnect out=1 after A->B is established: en_o=0 and done_o two cycles after acceptance.
- Assert RES_in during LD:
  - CS and LOAD fall asynchronously; all outputs at reset values.
  - After release, the FIFO is empty.
